// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch pipeline stage.
// Owns the PC, issues in-order word-address requests to instruction memory
// under a credit limit, buffers returned instructions and presents them as a
// registered core::InsnBundle to the read stage. Supports stall and redirect.
// MAX_OUTSTANDING must be >= 2.
// Optional feature: define FETCH_PERF_CNT_EN to add three 32-bit performance
// counters (perf_fetched, perf_redirects, perf_stall_cycles).

package core;
   localparam int ADDR_WIDTH = 16;
   localparam int INSN_WIDTH = 32;
   localparam logic [ADDR_WIDTH-1:0] INSN_ADDR_START = 16'h0010;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_WIDTH-1:0] addr;
      logic [INSN_WIDTH-1:0] insn;
   } InsnBundle;
endpackage

module fetch_stage #(
   parameter int                    ADDR_WIDTH      = core::ADDR_WIDTH,
   parameter int                    INSN_WIDTH      = core::INSN_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] INSN_ADDR_START = core::INSN_ADDR_START,
   parameter int                    MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [INSN_WIDTH-1:0] imem_rsp_data,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]           perf_fetched,
   output logic [31:0]           perf_redirects,
   output logic [31:0]           perf_stall_cycles,
`endif
   output core::InsnBundle       stage_out_insn
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CW:0] MAX_CREDIT = (CW + 1)'(MAX_OUTSTANDING);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] pc;
   logic [CW-1:0]         outstanding, occupancy, discard, out_after_rsp;
   logic [CW:0]           credit_used;
   logic [PW-1:0]         aq_wr, aq_rd, bf_wr, bf_rd;
   logic [ADDR_WIDTH-1:0] aq_mem  [MAX_OUTSTANDING];
   logic [ADDR_WIDTH-1:0] bf_addr [MAX_OUTSTANDING];
   logic [INSN_WIDTH-1:0] bf_insn [MAX_OUTSTANDING];
   logic                  rsp_ok, drain_rsp, handshake, push, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
   endfunction

   // Request/credit logic and the push/pop decisions for the instruction buffer
   always_comb begin
      rsp_ok         = imem_rsp_valid && (outstanding != '0);
      out_after_rsp  = outstanding - CW'(rsp_ok);
      drain_rsp      = imem_rsp_valid && (discard != '0);
      credit_used    = {1'b0, outstanding} + {1'b0, occupancy};
      imem_req_valid = (state == RUN) && !redirect_valid && (credit_used < MAX_CREDIT);
      imem_req_addr  = pc;
      handshake      = imem_req_valid && imem_req_ready;
      push           = (state == RUN) && !redirect_valid && rsp_ok;
      pop            = !redirect_valid && !stall && (occupancy != '0);
   end

   // Next state: DRAIN swallows responses belonging to requests issued before a redirect
   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (redirect_valid && (out_after_rsp != '0)) state_next = DRAIN;
         DRAIN:   if (!redirect_valid && ((discard - CW'(drain_rsp)) == '0)) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else      state <= state_next;
   end

   // PC, credit counters, queue pointers and the registered output bundle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc             <= INSN_ADDR_START;
         outstanding    <= '0;
         discard        <= '0;
         occupancy      <= '0;
         aq_wr          <= '0;
         aq_rd          <= '0;
         bf_wr          <= '0;
         bf_rd          <= '0;
         stage_out_insn <= '0;
      end else begin
         if (redirect_valid)  pc <= redirect_addr;
         else if (handshake)  pc <= pc + 1'b1;

         outstanding <= outstanding + CW'(handshake) - CW'(rsp_ok);

         if (redirect_valid)                     discard <= out_after_rsp;
         else if ((state == DRAIN) && drain_rsp) discard <= discard - 1'b1;

         if (redirect_valid) begin
            aq_wr     <= '0;
            aq_rd     <= '0;
            bf_wr     <= '0;
            bf_rd     <= '0;
            occupancy <= '0;
         end else begin
            if (handshake) aq_wr <= ptr_inc(aq_wr);
            if (push) begin
               aq_rd <= ptr_inc(aq_rd);
               bf_wr <= ptr_inc(bf_wr);
            end
            if (pop) bf_rd <= ptr_inc(bf_rd);
            occupancy <= occupancy + CW'(push) - CW'(pop);
         end

         if (redirect_valid) begin
            stage_out_insn.valid <= 1'b0;
         end else if (!stall) begin
            stage_out_insn.valid <= (occupancy != '0);
            if (occupancy != '0) begin
               stage_out_insn.addr <= bf_addr[bf_rd];
               stage_out_insn.insn <= bf_insn[bf_rd];
            end
         end
      end
   end

   // Queue storage: request addresses in flight and returned instructions
   always_ff @(posedge clk) begin
      if (handshake) aq_mem[aq_wr] <= pc;
      if (push) begin
         bf_addr[bf_wr] <= aq_mem[aq_rd];
         bf_insn[bf_wr] <= imem_rsp_data;
      end
   end

`ifndef SYNTHESIS
   rsp_without_request: assert property (@(posedge clk) disable iff (!rst)
      imem_rsp_valid |-> (outstanding != '0))
      else $error("fetch_stage: memory response with no request outstanding");
`endif

`ifdef FETCH_PERF_CNT_EN
   // Performance counters: delivered instructions, redirect cycles, stalled valid cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched      <= '0;
         perf_redirects    <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (pop)                                   perf_fetched      <= perf_fetched + 1'b1;
         if (redirect_valid)                        perf_redirects    <= perf_redirects + 1'b1;
         if (stall && stage_out_insn.valid)         perf_stall_cycles <= perf_stall_cycles + 1'b1;
      end
   end
`endif

endmodule
